// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared widths, decoder function codes and LSU types
package simple_processor_pkg;

  localparam int ADDR_WIDTH     = 16;
  localparam int DATA_WIDTH     = 16;
  localparam int LSU_IMM_WIDTH  = 6;
  localparam int REG_ADDR_WIDTH = 3;

  // Memory operations occupy the top two codes of the decoder function space.
  typedef enum logic [2:0] {
    FUNC_ADD   = 3'd0,
    FUNC_SUB   = 3'd1,
    FUNC_AND   = 3'd2,
    FUNC_OR    = 3'd3,
    FUNC_XOR   = 3'd4,
    FUNC_LI    = 3'd5,
    FUNC_LOAD  = 3'd6,
    FUNC_STORE = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  function automatic logic is_mem_op(input func_t f);
    return (f == FUNC_LOAD) || (f == FUNC_STORE);
  endfunction

  function automatic logic is_store_op(input func_t f);
    return f == FUNC_STORE;
  endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// rtl/lsu_timeout_ctr.sv - counts unacknowledged ACCESS cycles and flags the abort threshold
module lsu_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // A zero threshold means the access may wait forever.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: effective address, dmem handshake, PC stall and load write-back
module load_store_unit
  import simple_processor_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      valid_i,
  input  logic                      is_store_i,
  input  logic [MEM_DATA_WIDTH-1:0] rs1_data_i,
  input  logic [MEM_DATA_WIDTH-1:0] rs2_data_i,
  input  logic [LSU_IMM_WIDTH-1:0]  imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      stall_o,
  output logic                      wb_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] wb_data_o,
  output logic                      err_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                      dmem_ack_i
);

  lsu_state_t                state_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [MEM_DATA_WIDTH-1:0] ea_sum;
  logic [MEM_ADDR_WIDTH-1:0] ea;
  logic                      misaligned;
  logic                      tmo_expired;

  assign ea_sum     = rs1_data_i
                    + {{(MEM_DATA_WIDTH-LSU_IMM_WIDTH){imm_i[LSU_IMM_WIDTH-1]}}, imm_i};
  assign ea         = MEM_ADDR_WIDTH'(ea_sum);
  assign misaligned = (MEM_DATA_WIDTH == 16) && ea_sum[0];

  // RESP drops the stall so the PC advances at the end of the response cycle.
  assign stall_o = (state_q == ACCESS) || ((state_q == IDLE) && valid_i);

  lsu_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .clear  (state_q != ACCESS),
    .enable ((state_q == ACCESS) && !dmem_ack_i),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      err_o        <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            rd_q         <= rd_addr_i;
            dmem_we_o    <= is_store_i;
            dmem_addr_o  <= ea;
            dmem_wdata_o <= is_store_i ? rs2_data_i : '0;
            if (misaligned) begin
              state_q <= RESP;
              err_o   <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              dmem_req_o <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (dmem_ack_i) begin
            state_q    <= RESP;
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) begin
              wb_valid_o <= 1'b1;
              wb_addr_o  <= rd_q;
              wb_data_o  <= dmem_rdata_i;
            end
          end else if (tmo_expired) begin
            state_q    <= RESP;
            dmem_req_o <= 1'b0;
            err_o      <= 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        valid_i;
  logic        is_store_i;
  logic [15:0] rs1_data_i;
  logic [15:0] rs2_data_i;
  logic [5:0]  imm_i;
  logic [2:0]  rd_addr_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [2:0]  wb_addr_o;
  logic [15:0] wb_data_o;
  logic        err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [15:0] dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic [15:0] dmem_rdata_i;
  logic        dmem_ack_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] model_wb_data;
  logic [2:0]  model_wb_addr;

  always #5 clk_i = ~clk_i;

  load_store_unit #(
    .MEM_ADDR_WIDTH(16),
    .MEM_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .valid_i     (valid_i),
    .is_store_i  (is_store_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .imm_i       (imm_i),
    .rd_addr_i   (rd_addr_i),
    .stall_o     (stall_o),
    .wb_valid_o  (wb_valid_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .err_o       (err_o),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i),
    .dmem_ack_i  (dmem_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // d = ACCESS cycles before the acked one; d < 0 means memory never acks.
  task automatic run_op(input string tag, input bit st, input logic [15:0] rs1,
                        input logic [15:0] rs2, input logic [5:0] imm, input logic [2:0] rd,
                        input int d, input logic [15:0] rdata);
    int s_imm, a, exp_req, req_n, stall_n, wbv_n, err_n, resp_at, field_bad;
    bit mis, ok, done;
    logic [15:0] exp_wdata, seen_wb_data;
    logic [2:0]  seen_wb_addr;
    s_imm     = (imm >= 6'd32) ? int'(imm) - 64 : int'(imm);
    a         = (int'(rs1) + s_imm) & 32'hFFFF;
    mis       = (a % 2) != 0;
    ok        = !mis && d >= 0 && d < 16;
    exp_req   = mis ? 0 : (ok ? d + 1 : 16);
    exp_wdata = st ? rs2 : 16'h0;
    req_n = 0; stall_n = 0; wbv_n = 0; err_n = 0; resp_at = -1; field_bad = 0;
    done = 0;
    seen_wb_data = 'x; seen_wb_addr = 'x;

    valid_i = 1'b1; is_store_i = st; rs1_data_i = rs1; rs2_data_i = rs2;
    imm_i = imm; rd_addr_i = rd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stall_o) stall_n++;
      if (wb_valid_o) begin
        wbv_n++;
        seen_wb_data = wb_data_o;
        seen_wb_addr = wb_addr_o;
      end
      if (err_o) err_n++;
      if (dmem_req_o) begin
        if (dmem_addr_o !== a[15:0] || dmem_we_o !== st || dmem_wdata_o !== exp_wdata)
          field_bad++;
        dmem_ack_i   = (d >= 0 && req_n == d);
        dmem_rdata_i = rdata;
        req_n++;
      end else begin
        dmem_ack_i   = 1'($urandom_range(0, 1));
        dmem_rdata_i = 16'($urandom);
      end
      if (cyc > 0 && !stall_o) begin
        done    = 1;
        resp_at = cyc;
      end else begin
        @(negedge clk_i);
      end
    end
    valid_i    = 1'b0;
    dmem_ack_i = 1'b0;

    if (ok && !st) begin
      model_wb_data = rdata;
      model_wb_addr = rd;
    end
    check({tag, "/done"},      32'(done),      32'd1);
    check({tag, "/resp_at"},   32'(resp_at),   32'(exp_req + 1));
    check({tag, "/req_cyc"},   32'(req_n),     32'(exp_req));
    check({tag, "/stall_cyc"}, 32'(stall_n),   32'(exp_req + 1));
    check({tag, "/fields"},    32'(field_bad), 32'd0);
    check({tag, "/wb_cnt"},    32'(wbv_n),     32'((ok && !st) ? 1 : 0));
    check({tag, "/err_cnt"},   32'(err_n),     32'(ok ? 0 : 1));
    if (ok && !st) begin
      check({tag, "/wb_addr"}, 32'(seen_wb_addr), 32'(rd));
      check({tag, "/wb_data"}, 32'(seen_wb_data), 32'(rdata));
    end
    @(negedge clk_i);
    #1;
    check({tag, "/idle_req"},   32'(dmem_req_o), 32'd0);
    check({tag, "/idle_stall"}, 32'(stall_o),    32'd0);
    check({tag, "/hold_data"},  32'(wb_data_o),  32'(model_wb_data));
    check({tag, "/hold_addr"},  32'(wb_addr_o),  32'(model_wb_addr));
  endtask

  initial begin
    int r, d;
    arst_ni = 1'b0; valid_i = 1'b0; is_store_i = 1'b0; rs1_data_i = '0; rs2_data_i = '0;
    imm_i = '0; rd_addr_i = '0; dmem_rdata_i = '0; dmem_ack_i = 1'b0;
    model_wb_data = '0; model_wb_addr = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst/req",      32'(dmem_req_o),   32'd0);
    check("rst/stall",    32'(stall_o),      32'd0);
    check("rst/wb_valid", 32'(wb_valid_o),   32'd0);
    check("rst/err",      32'(err_o),        32'd0);
    check("rst/wb_data",  32'(wb_data_o),    32'd0);
    check("rst/addr",     32'(dmem_addr_o),  32'd0);
    check("rst/wdata",    32'(dmem_wdata_o), 32'd0);
    arst_ni = 1'b1;

    run_op("load_imm_ack",  1'b0, 16'h0100, 16'h0000, 6'h04, 3'd3, 0,  16'hBEEF);
    run_op("store_delay4",  1'b1, 16'h0200, 16'h1234, 6'h3E, 3'd1, 3,  16'h0000);
    run_op("wrap",          1'b0, 16'hFFFE, 16'h0000, 6'h04, 3'd5, 1,  16'h5A5A);
    run_op("misaligned",    1'b0, 16'h0101, 16'h0000, 6'h00, 3'd2, 0,  16'h1111);
    run_op("timeout",       1'b0, 16'h0400, 16'h0000, 6'h00, 3'd4, -1, 16'h2222);
    run_op("ack_cycle16",   1'b0, 16'h0400, 16'h0000, 6'h02, 3'd6, 15, 16'hC0DE);
    run_op("store_timeout", 1'b1, 16'h0600, 16'hAAAA, 6'h20, 3'd0, -1, 16'h0000);

    // Asynchronous reset in the middle of an access.
    valid_i = 1'b1; is_store_i = 1'b0; rs1_data_i = 16'h0300; imm_i = 6'h00; rd_addr_i = 3'd7;
    dmem_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("mid/req_before", 32'(dmem_req_o), 32'd1);
    #2;
    arst_ni = 1'b0;
    valid_i = 1'b0;
    #1;
    check("mid/req",      32'(dmem_req_o), 32'd0);
    check("mid/stall",    32'(stall_o),    32'd0);
    check("mid/wb_valid", 32'(wb_valid_o), 32'd0);
    check("mid/err",      32'(err_o),      32'd0);
    model_wb_data = '0;
    model_wb_addr = '0;
    @(negedge clk_i);
    arst_ni = 1'b1;
    run_op("after_reset", 1'b0, 16'h0300, 16'h0000, 6'h10, 3'd7, 2, 16'h7E57);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      d = r;
      else if (r == 6) d = 15;
      else if (r == 7) d = -1;
      else             d = $urandom_range(0, 3);
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 16'($urandom),
             16'($urandom), 6'($urandom), 3'($urandom), d, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage downstream of the execution block and instruction decoder.
- Takes a decoded load/store, computes the effective address (rs1 + sign-extended imm) and drives the processor's dmem request/ack interface.
- Stalls the PC while the access is outstanding.
- For loads, delivers a one-cycle register-file write-back of the read data.

Parameters:
- MEM_ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, data address bus width.
- MEM_DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, data bus / register width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles without ack before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  global clock, rising edge
- arst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  decoder presents a memory instruction this cycle
- is_store_i  in  1  1 = store, 0 = load
- rs1_data_i  in  MEM_DATA_WIDTH  base register value
- rs2_data_i  in  MEM_DATA_WIDTH  store data
- imm_i  in  6  signed offset
- rd_addr_i  in  3  load destination register
- stall_o  out  1  hold PC / decoder
- wb_valid_o  out  1  register write-back strobe (loads only)
- wb_addr_o  out  3  write-back register
- wb_data_o  out  MEM_DATA_WIDTH  write-back data
- err_o  out  1  one-cycle pulse: misaligned or timed-out access
- dmem_req_o  out  1  data request
- dmem_we_o  out  1  write enable
- dmem_addr_o  out  MEM_ADDR_WIDTH  data address
- dmem_wdata_o  out  MEM_DATA_WIDTH  write data
- dmem_rdata_i  in  MEM_DATA_WIDTH  read data
- dmem_ack_i  in  1  request completed

Behaviour:
- Reset is arst_ni, asynchronous, active-low; clock is clk_i.
- Reset state: IDLE. All registered outputs and internal registers = 0; stall_o = 0.
- Reset mid-access drops dmem_req_o immediately. No write-back and no err_o are produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - stall_o = valid_i (combinational).
  - On valid_i, latch the request fields and go to ACCESS.
    - addr = rs1_data_i + sign_extend(imm_i), computed at MEM_DATA_WIDTH, then truncated/zero-extended to MEM_ADDR_WIDTH; wrap-around is modulo 2^width.
    - Also latch is_store, wdata = rs2_data_i, rd_addr.
  - Misaligned address (addr[0]=1 when MEM_DATA_WIDTH=16): no memory request; go directly to RESP with error flag set.
- ACCESS:
  - dmem_req_o=1; dmem_we_o, dmem_addr_o and dmem_wdata_o are registered and stable until ack.
  - dmem_wdata_o=0 for loads. stall_o=1.
  - On dmem_ack_i: capture dmem_rdata_i (loads) and go to RESP. dmem_req_o drops in the following cycle.
  - Timeout counter: cleared on entry to ACCESS, increments each non-ack cycle. When count == TIMEOUT_CYCLES-1 with no ack, drop the request and go to RESP with error flag set.
  - Ack in the same cycle as the timeout threshold counts as success.
- RESP (exactly 1 cycle):
  - stall_o=0, so the PC advances at the end of this cycle.
  - Successful load: wb_valid_o=1, wb_addr_o=rd_addr, wb_data_o=captured data.
  - Successful store: no write-back.
  - Error: err_o=1, wb_valid_o=0.
  - valid_i is ignored in RESP (same instruction still presented). Return to IDLE.
- Latency with immediate ack: 3 cycles per memory instruction (IDLE issue, 1× ACCESS, RESP).
- Spurious dmem_ack_i in IDLE/RESP is ignored.
- wb_data_o / wb_addr_o hold their last values when wb_valid_o=0.

Decomposition:
- Add to simple_processor_pkg:
  - lsu_state_t enum (IDLE, ACCESS, RESP)
  - LSU_IMM_WIDTH = 6
  - REG_ADDR_WIDTH = 3
- Decoder gains mem-op and is_store outputs in the existing func_t space.
- Sub-module lsu_timeout_ctr: clear, enable, threshold compare, disabled when TIMEOUT_CYCLES=0.
- FSM and datapath stay in load_store_unit.

Test Plan:
- Load, immediate ack: rs1=0x0100, imm=6'h04, rd=3, rdata=0xBEEF.
  - Required: dmem_addr_o=0x0104, we=0, req high 1 cycle.
  - wb_valid_o pulse with wb_addr_o=3, wb_data_o=0xBEEF.
  - stall_o high for exactly 2 cycles.
- Store, 4-cycle ack delay: rs1=0x0200, imm=6'h3E (−2), rs2=0x1234.
  - Required: addr=0x01FE, we=1, wdata=0x1234 stable for 4 cycles.
  - No wb_valid_o; err_o=0.
- Wrap-around: rs1=0xFFFE, imm=6'h04.
  - Required: addr=0x0002.
- Misaligned: rs1=0x0101, imm=0.
  - Required: dmem_req_o never asserted; err_o pulse 1 cycle after issue; no write-back.
- Timeout, TIMEOUT_CYCLES=16, ack never given:
  - Required: req high for 16 cycles then drops; err_o pulse; stall_o releases.
  - Repeat with ack on cycle 16 → success, no err_o.
- arst_ni low during ACCESS:
  - Required: req/stall/wb/err all 0 asynchronously; next load after reset completes normally.
